// File: rtl/grain_128a.sv
// Grain-128a keystream generator (no authentication): 128-bit LFSR s and 128-bit NFSR b.
// Loads key/IV, runs 256 initialisation rounds, then produces one keystream bit per enabled clock.
module grain_128a (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         initialise,
  input  logic         enable,
  input  logic [95:0]  IV,
  input  logic [127:0] key,
  output logic         key_stream,
  output logic         ready
);

  localparam int unsigned INIT_ROUNDS = 256;
  localparam logic [8:0]  CNT_LAST    = 9'(INIT_ROUNDS - 1);

  typedef enum logic [1:0] {LOAD, INIT, RUN} state_t;

  state_t       state;
  logic [127:0] s;
  logic [127:0] b;
  logic [8:0]   cnt;
  logic [127:0] key_bits;
  logic [95:0]  iv_bits;
  logic         f, g, h, y;

  // Bit 0 of the key/IV sits in the MSB of the port, so reverse into register order.
  always_comb begin
    key_bits = '0;
    iv_bits  = '0;
    for (int i = 0; i < 128; i++) key_bits[i] = key[127-i];
    for (int i = 0; i < 96; i++)  iv_bits[i]  = IV[95-i];
  end

  assign f = s[0] ^ s[7] ^ s[38] ^ s[70] ^ s[81] ^ s[96];

  assign g = s[0] ^ b[0] ^ b[26] ^ b[56] ^ b[91] ^ b[96]
           ^ (b[3] & b[67]) ^ (b[11] & b[13]) ^ (b[17] & b[18])
           ^ (b[27] & b[59]) ^ (b[40] & b[48]) ^ (b[61] & b[65])
           ^ (b[68] & b[84]) ^ (b[88] & b[92] & b[93] & b[95])
           ^ (b[22] & b[24] & b[25]) ^ (b[70] & b[78] & b[82]);

  assign h = (b[12] & s[8]) ^ (s[13] & s[20]) ^ (b[95] & s[42])
           ^ (s[60] & s[79]) ^ (b[12] & b[95] & s[94]);

  assign y = h ^ s[93] ^ b[2] ^ b[15] ^ b[36] ^ b[45] ^ b[64] ^ b[73] ^ b[89];

  assign key_stream = y & ready & enable;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s     <= '0;
      b     <= '0;
      cnt   <= '0;
      ready <= 1'b0;
      state <= LOAD;
    end else if (initialise) begin
      ready <= 1'b0;
      state <= LOAD;
    end else begin
      case (state)
        LOAD: begin
          b     <= key_bits;
          s     <= {1'b0, {31{1'b1}}, iv_bits};
          cnt   <= '0;
          state <= INIT;
        end
        // During initialisation the output bit is fed back into both registers.
        INIT: begin
          s   <= {f ^ y, s[127:1]};
          b   <= {g ^ y, b[127:1]};
          cnt <= cnt + 9'd1;
          if (cnt == CNT_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (enable) begin
            s <= {f, s[127:1]};
            b <= {g, b[127:1]};
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_grain_128a.sv
// Self-checking bench for grain_128a: a tap-list reference model of Grain-128a feeds an
// expected-bit queue that is drained as the DUT keystream is sampled.
module tb_grain_128a;

  logic         clk;
  logic         n_reset;
  logic         initialise;
  logic         enable;
  logic [95:0]  IV;
  logic [127:0] key;
  logic         key_stream;
  logic         ready;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];

  bit ms[128];
  bit mb[128];

  localparam logic [127:0] KEY_A = 128'h786477e1dc256ca0f2d71da33e3a6042;
  localparam logic [95:0]  IV_A  = 96'h32a4ba0884bd27d3120878f2;

  grain_128a dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .initialise (initialise),
    .enable     (enable),
    .IV         (IV),
    .key        (key),
    .key_stream (key_stream),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model, written from the tap lists of the cipher description.
  function automatic bit model_f();
    int taps[6] = '{0, 7, 38, 70, 81, 96};
    bit r = 1'b0;
    foreach (taps[i]) r ^= ms[taps[i]];
    return r;
  endfunction

  function automatic bit model_g();
    int lin[5] = '{0, 26, 56, 91, 96};
    int pa[7]  = '{3, 11, 17, 27, 40, 61, 68};
    int pb[7]  = '{67, 13, 18, 59, 48, 65, 84};
    bit r = ms[0];
    foreach (lin[i]) r ^= mb[lin[i]];
    foreach (pa[i])  r ^= mb[pa[i]] & mb[pb[i]];
    r ^= mb[88] & mb[92] & mb[93] & mb[95];
    r ^= mb[22] & mb[24] & mb[25];
    r ^= mb[70] & mb[78] & mb[82];
    return r;
  endfunction

  function automatic bit model_y();
    int lin[7] = '{2, 15, 36, 45, 64, 73, 89};
    bit r;
    r = (mb[12] & ms[8]) ^ (ms[13] & ms[20]) ^ (mb[95] & ms[42])
      ^ (ms[60] & ms[79]) ^ (mb[12] & mb[95] & ms[94]) ^ ms[93];
    foreach (lin[i]) r ^= mb[lin[i]];
    return r;
  endfunction

  task automatic model_advance(input bit init_mode);
    bit yv, fv, gv;
    yv = model_y();
    fv = model_f();
    gv = model_g();
    for (int i = 0; i < 127; i++) begin
      ms[i] = ms[i+1];
      mb[i] = mb[i+1];
    end
    ms[127] = fv ^ (init_mode & yv);
    mb[127] = gv ^ (init_mode & yv);
  endtask

  task automatic model_load(input logic [127:0] k, input logic [95:0] v);
    for (int i = 0; i < 128; i++) mb[i] = k[127-i];
    for (int i = 0; i < 96; i++)  ms[i] = v[95-i];
    for (int i = 96; i < 127; i++) ms[i] = 1'b1;
    ms[127] = 1'b0;
    for (int r = 0; r < 256; r++) model_advance(1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called just after an edge; counts edges until ready rises (bounded).
  task automatic wait_ready(input string tag, input int want);
    int n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, n, want);
  endtask

  // Drives enable for n cycles, queueing the model's expected bit and comparing mid-cycle.
  task automatic applyStimulus(input int n, input logic en, input string tag);
    logic exp_bit;
    for (int i = 0; i < n; i++) begin
      enable = en;
      if (en) begin
        exp_q.push_back(model_y());
        model_advance(1'b0);
      end else begin
        exp_q.push_back(1'b0);
      end
      #2;
      exp_bit = exp_q.pop_front();
      checkOutput(tag, key_stream, exp_bit);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_reset    = 1'b0;
    initialise = 1'b0;
    enable     = 1'b0;
    key        = KEY_A;
    IV         = IV_A;

    #3;
    enable = 1'b1;
    #1;
    checkOutput("reset_ready", ready, 1'b0);
    checkOutput("reset_ks", key_stream, 1'b0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    wait_ready("ready_edge_a", 257);

    model_load(KEY_A, IV_A);
    applyStimulus(256, 1'b1, "ks_a");

    // Gapped enable must yield the same bit sequence as continuous enable.
    for (int r = 0; r < 16; r++) begin
      applyStimulus(1, 1'b1, "gap_on");
      applyStimulus(2, 1'b0, "gap_off");
      applyStimulus(1, 1'b1, "gap_on");
    end
    checkOutput("gap_ready", ready, 1'b1);

    enable     = 1'b1;
    initialise = 1'b1;
    @(posedge clk);
    #1;
    initialise = 1'b0;
    checkOutput("init_pulse_ready", ready, 1'b0);
    checkOutput("init_pulse_ks", key_stream, 1'b0);
    wait_ready("ready_edge_restart", 257);
    model_load(KEY_A, IV_A);
    applyStimulus(64, 1'b1, "ks_restart");

    enable  = 1'b1;
    n_reset = 1'b0;
    #1;
    checkOutput("async_rst_ready", ready, 1'b0);
    checkOutput("async_rst_ks", key_stream, 1'b0);
    key = '0;
    IV  = '0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    // Key/IV changes after the load edge must be ignored.
    key = KEY_A;
    IV  = IV_A;
    wait_ready("ready_edge_zero", 247);
    model_load('0, '0);
    applyStimulus(64, 1'b1, "ks_zero");

    n_reset = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (101) begin
      @(posedge clk);
      #1;
    end
    enable  = 1'b1;
    n_reset = 1'b0;
    #1;
    checkOutput("init_rst_ready", ready, 1'b0);
    checkOutput("init_rst_ks", key_stream, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("held_rst_ready", ready, 1'b0);
    n_reset = 1'b1;
    wait_ready("ready_edge_rerun", 257);
    model_load(KEY_A, IV_A);
    applyStimulus(32, 1'b1, "ks_rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
